// File: rtl/usb_pkg.sv
// Shared USB byte/word types and the serial CRC16 update used by RX checking
// and TX appending.
package usb_pkg;

  typedef logic [7:0]  bus8_t;
  typedef logic [15:0] bus16_t;

  localparam bus16_t CRC16_INIT     = 16'hFFFF;
  localparam bus16_t CRC16_RESIDUAL = 16'h800D;
  localparam bus16_t CRC16_POLY     = 16'h8005;

  // Data enters LSB first; the register shifts toward bit 15, the x^15 term.
  function automatic bus16_t crc16_byte(bus16_t crc, bus8_t d);
    bus16_t c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_rx_crc16_chk_if.sv
// Byte stream in from the receiver, payload stream and packet status out.
interface usb_rx_crc16_chk_if #(parameter int LEN_W = 11);
  import usb_pkg::*;

  bus8_t            rx_data;
  logic             rx_valid;
  logic             rx_sop;
  logic             rx_eop;
  logic             rx_abort;
  bus8_t            pl_data;
  logic             pl_valid;
  logic             done;
  logic             crc_ok;
  logic             err_short;
  logic             err_ovf;
  logic             err_abort;
  logic [LEN_W-1:0] len;
  logic             busy;

  modport master (
    output rx_data, rx_valid, rx_sop, rx_eop, rx_abort,
    input  pl_data, pl_valid, done, crc_ok, err_short, err_ovf, err_abort, len, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_sop, rx_eop, rx_abort,
    output pl_data, pl_valid, done, crc_ok, err_short, err_ovf, err_abort, len, busy
  );

endinterface

// File: rtl/usb_rx_crc16_chk.sv
// RX CRC16 checker: strips the trailing CRC field via a 2-byte holdback and
// reports residual check, length and error status one cycle after EOP/abort.
module usb_rx_crc16_chk
  import usb_pkg::*;
#(
  parameter int     MAX_LEN  = 1024,
  parameter int     LEN_W    = 11,
  parameter bus16_t RESIDUAL = CRC16_RESIDUAL
) (
  input logic clk,
  input logic rst_n,
  usb_rx_crc16_chk_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t           state_reg, state_next;
  bus16_t           crc_reg, crc_next;
  bus8_t            hold0_reg, hold0_next;
  bus8_t            hold1_reg, hold1_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             ovf_reg, ovf_next;
  bus8_t            pl_data_reg, pl_data_next;
  logic             pl_valid_reg, pl_valid_next;
  logic             done_reg, done_next;
  logic             crc_ok_reg, crc_ok_next;
  logic             err_short_reg, err_short_next;
  logic             err_ovf_reg, err_ovf_next;
  logic             err_abort_reg, err_abort_next;
  logic             abort_evt, start, accept, eop_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      crc_reg       <= CRC16_INIT;
      hold0_reg     <= '0;
      hold1_reg     <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      ovf_reg       <= 1'b0;
      pl_data_reg   <= '0;
      pl_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      crc_ok_reg    <= 1'b0;
      err_short_reg <= 1'b0;
      err_ovf_reg   <= 1'b0;
      err_abort_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      crc_reg       <= crc_next;
      hold0_reg     <= hold0_next;
      hold1_reg     <= hold1_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      ovf_reg       <= ovf_next;
      pl_data_reg   <= pl_data_next;
      pl_valid_reg  <= pl_valid_next;
      done_reg      <= done_next;
      crc_ok_reg    <= crc_ok_next;
      err_short_reg <= err_short_next;
      err_ovf_reg   <= err_ovf_next;
      err_abort_reg <= err_abort_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    crc_next       = crc_reg;
    hold0_next     = hold0_reg;
    hold1_next     = hold1_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    ovf_next       = ovf_reg;
    pl_data_next   = pl_data_reg;
    pl_valid_next  = 1'b0;
    done_next      = 1'b0;
    crc_ok_next    = 1'b0;
    err_short_next = 1'b0;
    err_ovf_next   = 1'b0;
    err_abort_next = 1'b0;

    // Abort wins over any byte or EOP presented in the same cycle.
    abort_evt = (state_reg == RECV) && bus.rx_abort;
    start     = bus.rx_valid && bus.rx_sop && !abort_evt;
    accept    = start || ((state_reg == RECV) && bus.rx_valid && !abort_evt);
    eop_evt   = bus.rx_eop && !abort_evt && ((state_reg == RECV) || start);

    if (accept) begin
      crc_next = crc16_byte(start ? CRC16_INIT : crc_reg, bus.rx_data);
      if (start) begin
        cnt_next = '0;
        len_next = '0;
        ovf_next = 1'b0;
      end
      // A full holdback means its oldest byte cannot be CRC and is payload.
      if (cnt_next == 2'd2) begin
        if (len_next == MAX_LEN_L) begin
          ovf_next = 1'b1;
        end else begin
          pl_valid_next = 1'b1;
          pl_data_next  = hold1_reg;
          len_next      = len_next + 1'b1;
        end
      end else begin
        cnt_next = cnt_next + 2'd1;
      end
      hold1_next = hold0_reg;
      hold0_next = bus.rx_data;
      state_next = RECV;
    end

    if (eop_evt) begin
      done_next      = 1'b1;
      crc_ok_next    = (cnt_next == 2'd2) && (crc_next == RESIDUAL) && !ovf_next;
      err_short_next = (cnt_next != 2'd2);
      err_ovf_next   = ovf_next;
      cnt_next       = '0;
      state_next     = IDLE;
    end

    if (abort_evt) begin
      done_next      = 1'b1;
      err_abort_next = 1'b1;
      cnt_next       = '0;
      state_next     = IDLE;
    end
  end

  assign bus.pl_data   = pl_data_reg;
  assign bus.pl_valid  = pl_valid_reg;
  assign bus.done      = done_reg;
  assign bus.crc_ok    = crc_ok_reg;
  assign bus.err_short = err_short_reg;
  assign bus.err_ovf   = err_ovf_reg;
  assign bus.err_abort = err_abort_reg;
  assign bus.len       = len_reg;
  assign bus.busy      = (state_reg == RECV);

endmodule

// File: tb/tb_usb_rx_crc16_chk.sv
// Directed, table-driven bench for usb_rx_crc16_chk, with a second instance
// built for MAX_LEN=4 to exercise overflow.
module tb_usb_rx_crc16_chk;

  typedef struct {
    int           n;
    logic [95:0]  d;
    bit           eop_last;
    bit           on4;
    bit           ok;
    bit           sh;
    bit           ov;
    int           len;
    int           npl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  usb_rx_crc16_chk_if #(.LEN_W(11)) bus ();
  usb_rx_crc16_chk_if #(.LEN_W(11)) bus4 ();

  usb_rx_crc16_chk #(.MAX_LEN(1024), .LEN_W(11), .RESIDUAL(16'h800D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  usb_rx_crc16_chk #(.MAX_LEN(4), .LEN_W(11), .RESIDUAL(16'h800D)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus4.rx_data  = bus.rx_data;
  assign bus4.rx_valid = bus.rx_valid;
  assign bus4.rx_sop   = bus.rx_sop;
  assign bus4.rx_eop   = bus.rx_eop;
  assign bus4.rx_abort = bus.rx_abort;

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  logic [7:0]  pl_q[$];
  logic [7:0]  pl4_q[$];
  int          done_cnt = 0;
  int          done4_cnt = 0;
  logic [3:0]  flags, flags4;
  logic [10:0] len_d, len4_d;

  always @(negedge clk) begin
    if (bus.pl_valid) pl_q.push_back(bus.pl_data);
    if (bus4.pl_valid) pl4_q.push_back(bus4.pl_data);
    if (bus.done) begin
      done_cnt++;
      flags = {bus.crc_ok, bus.err_short, bus.err_ovf, bus.err_abort};
      len_d = bus.len;
    end
    if (bus4.done) begin
      done4_cnt++;
      flags4 = {bus4.crc_ok, bus4.err_short, bus4.err_ovf, bus4.err_abort};
      len4_d = bus4.len;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic v, input logic sop,
                     input logic eop, input logic abort);
    @(posedge clk);
    #1;
    bus.rx_data  = d;
    bus.rx_valid = v;
    bus.rx_sop   = sop;
    bus.rx_eop   = eop;
    bus.rx_abort = abort;
  endtask

  // Independent reflected-form USB CRC16; returns the transmitted CRC value.
  function automatic logic [15:0] crc_ref(input logic [95:0] d, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, d[i*8 +: 8]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int outs_word(input bit sel4);
    if (sel4)
      return int'({bus4.pl_data, bus4.pl_valid, bus4.done, bus4.crc_ok, bus4.err_short,
                   bus4.err_ovf, bus4.err_abort, bus4.len, bus4.busy});
    return int'({bus.pl_data, bus.pl_valid, bus.done, bus.crc_ok, bus.err_short,
                 bus.err_ovf, bus.err_abort, bus.len, bus.busy});
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int b0, pb, bad, nq, dc;
    logic [3:0]  fl;
    logic [10:0] ln;
    logic [7:0]  x;
    b0 = v.on4 ? done4_cnt : done_cnt;
    pb = v.on4 ? pl4_q.size() : pl_q.size();
    for (int i = 0; i < v.n; i++)
      put(v.d[i*8 +: 8], 1'b1, i == 0, v.eop_last && (i == v.n - 1), 1'b0);
    if (!v.eop_last) put(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    put(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dc = (v.on4 ? done4_cnt : done_cnt) - b0;
    fl = v.on4 ? flags4 : flags;
    ln = v.on4 ? len4_d : len_d;
    nq = (v.on4 ? pl4_q.size() : pl_q.size()) - pb;
    bad = 0;
    for (int j = 0; j < v.npl && j < nq; j++) begin
      x = v.on4 ? pl4_q[pb + j] : pl_q[pb + j];
      if (x !== v.d[j*8 +: 8]) bad++;
    end
    chk({tag, "_done"}, dc, 1);
    chk({tag, "_crc_ok"}, int'(fl[3]), int'(v.ok));
    chk({tag, "_err_short"}, int'(fl[2]), int'(v.sh));
    chk({tag, "_err_ovf"}, int'(fl[1]), int'(v.ov));
    chk({tag, "_err_abort"}, int'(fl[0]), 0);
    chk({tag, "_len"}, int'(ln), v.len);
    chk({tag, "_pl_count"}, nq, v.npl);
    chk({tag, "_pl_data"}, bad, 0);
    chk({tag, "_busy"}, int'(v.on4 ? bus4.busy : bus.busy), 0);
    $display("[TB] %s: n=%0d done=%0d flags=%b len=%0d payload=%0d", tag, v.n, dc, fl, ln, nq);
  endtask

  vec_t vt[6];

  initial begin
    logic [15:0] c;
    int b0, pb, nq, bad;
    rst_n = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 0; bus.rx_sop = 0; bus.rx_eop = 0; bus.rx_abort = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs_word(0), 0);
    chk("reset_outs4", outs_word(1), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      vt[k] = '{n: 11, d: '0, eop_last: 0, on4: 0, ok: 1, sh: 0, ov: 0, len: 9, npl: 9};
      for (int i = 0; i < 9; i++) vt[k].d[i*8 +: 8] = 8'h31 + 8'(i);
      vt[k].d[72 +: 8] = 8'hC8;
      vt[k].d[80 +: 8] = 8'hB4;
    end
    vt[0] = '{n: 2, d: '0, eop_last: 0, on4: 0, ok: 1, sh: 0, ov: 0, len: 0, npl: 0};
    vt[2].d[80 +: 8] = 8'hB5; vt[2].ok = 0;
    vt[3] = '{n: 1, d: '0, eop_last: 0, on4: 0, ok: 0, sh: 1, ov: 0, len: 0, npl: 0};
    vt[4].n = 8; vt[4].on4 = 1; vt[4].ok = 0; vt[4].ov = 1; vt[4].len = 4; vt[4].npl = 4;
    c = crc_ref(vt[4].d, 6);
    vt[4].d[48 +: 8] = c[7:0];
    vt[4].d[56 +: 8] = c[15:8];
    vt[4].d[64 +: 32] = '0;
    vt[5].eop_last = 1;

    for (int k = 0; k < 6; k++) run_vec($sformatf("vec%0d", k), vt[k]);

    // Abort after three bytes: one payload byte already out, then abort status.
    b0 = done_cnt; pb = pl_q.size();
    put(8'h31, 1, 1, 0, 0); put(8'h32, 1, 0, 0, 0); put(8'h33, 1, 0, 0, 0);
    put(8'h00, 0, 0, 0, 1); put(8'h00, 0, 0, 0, 0);
    repeat (3) @(posedge clk); @(negedge clk);
    chk("abort_done", done_cnt - b0, 1);
    chk("abort_flags", int'(flags), 4'b0001);
    chk("abort_len", int'(len_d), 1);
    chk("abort_pl_count", pl_q.size() - pb, 1);
    $display("[TB] abort: done=%0d flags=%b len=%0d", done_cnt - b0, flags, len_d);

    // New SOP mid-packet: old packet dropped silently, new one checks ok.
    b0 = done_cnt; pb = pl_q.size();
    put(8'h41, 1, 1, 0, 0); put(8'h42, 1, 0, 0, 0); put(8'h43, 1, 0, 0, 0);
    put(8'h44, 1, 0, 0, 0);
    @(negedge clk);
    chk("restart_busy", int'(bus.busy), 1);
    for (int i = 0; i < 11; i++) put(vt[1].d[i*8 +: 8], 1, i == 0, 0, 0);
    put(8'h00, 0, 0, 1, 0); put(8'h00, 0, 0, 0, 0);
    repeat (4) @(posedge clk); @(negedge clk);
    nq = pl_q.size() - pb;
    bad = 0;
    if (nq == 11) begin
      if (pl_q[pb] !== 8'h41 || pl_q[pb + 1] !== 8'h42) bad++;
      for (int j = 0; j < 9; j++) if (pl_q[pb + 2 + j] !== 8'h31 + 8'(j)) bad++;
    end
    chk("restart_done", done_cnt - b0, 1);
    chk("restart_flags", int'(flags), 4'b1000);
    chk("restart_len", int'(len_d), 9);
    chk("restart_pl_count", nq, 11);
    chk("restart_pl_data", bad, 0);
    $display("[TB] restart: done=%0d flags=%b len=%0d payload=%0d", done_cnt - b0, flags, len_d, nq);

    // Reset mid-packet: everything clears and no status strobe appears.
    b0 = done_cnt;
    put(8'h31, 1, 1, 0, 0); put(8'h32, 1, 0, 0, 0); put(8'h33, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.rx_valid = 0; bus.rx_sop = 0;
    @(posedge clk); @(negedge clk);
    chk("midreset_outs", outs_word(0), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk); @(negedge clk);
    chk("midreset_no_done", done_cnt - b0, 0);
    $display("[TB] midreset: outs=%0h done=%0d", outs_word(0), done_cnt - b0);
    run_vec("post_reset", vt[1]);

    // Stray byte, EOP and abort while idle are all ignored.
    b0 = done_cnt; pb = pl_q.size();
    put(8'h55, 1, 0, 0, 0); put(8'h00, 0, 0, 1, 0); put(8'h00, 0, 0, 0, 1);
    put(8'h00, 0, 0, 0, 0);
    repeat (3) @(posedge clk); @(negedge clk);
    chk("idle_no_done", done_cnt - b0, 0);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_no_pl", pl_q.size() - pb, 0);
    $display("[TB] idle: done=%0d busy=%0b payload=%0d", done_cnt - b0, bus.busy, pl_q.size() - pb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
